// File: rtl/memory_turn_ctrl.sv
// Memory-game turn controller: drives tile cursor/select/pair strobes, runs pick-compare-score loop, tracks scores and game end.
// Latency: cursor moves 1 cycle after btn_move; select strobe 1 cycle after btn_sel; par strobe 1 cycle after COMPARE.
// No backpressure: buttons outside PICK1/PICK2 or in DONE are dropped. Optional turn timeout: `define TURN_TIMEOUT_EN.
module memory_turn_ctrl #(
    parameter int N_TILES     = 16,
    parameter int IDX_W       = 4,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_move,
    input  logic                 btn_sel,
    input  logic [4*N_TILES-1:0] tile_state,
    output logic [N_TILES-1:0]   tile_cursor,
    output logic [N_TILES-1:0]   tile_select,
    output logic [N_TILES-1:0]   tile_par,
    output logic                 player,
    output logic [IDX_W-1:0]     cursor_idx,
    output logic [4:0]           score0,
    output logic [4:0]           score1,
    output logic                 game_over,
    output logic [1:0]           winner
);

    typedef enum logic [2:0] {
        PICK1, WAIT1, PICK2, WAIT2, COMPARE, PAR, NEXT, DONE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cur_q, cur_nxt, idx1_q, idx1_nxt, idx2_q, idx2_nxt;
    logic [3:0]         lab1_q, lab1_nxt, lab2_q, lab2_nxt;
    logic               player_q, player_nxt;
    logic [4:0]         score0_q, score0_nxt, score1_q, score1_nxt;
    logic [N_TILES-1:0] sel_q, sel_nxt;
    logic               timeout;

    logic [3:0]         st [N_TILES];
    logic [N_TILES-1:0] avail;
    logic               above_ok, from_ok;
    logic [IDX_W-1:0]   above_idx, from_idx, jj;
    int                 j;

    function automatic logic [N_TILES-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(N_TILES-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic is_label(input logic [3:0] v);
        return (v >= 4'd1) && (v <= 4'd8);
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] s);
        return (s == 5'd31) ? s : s + 5'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_TILES; i++) begin
            st[i]    = tile_state[4*i +: 4];
            avail[i] = (st[i] == 4'h0) || (st[i] == 4'hF);
        end
    end

    // Descending scan so the smallest offset from the cursor wins; offset 0 only counts for the at-or-after search.
    always_comb begin
        above_ok  = 1'b0;
        above_idx = cur_q;
        from_ok   = 1'b0;
        from_idx  = cur_q;
        j         = 0;
        jj        = '0;
        for (int k = N_TILES - 1; k >= 0; k--) begin
            j = int'(cur_q) + k;
            if (j >= N_TILES) j = j - N_TILES;
            jj = IDX_W'(j);
            if (avail[jj]) begin
                from_ok  = 1'b1;
                from_idx = jj;
                if (k != 0) begin
                    above_ok  = 1'b1;
                    above_idx = jj;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cur_nxt    = cur_q;
        idx1_nxt   = idx1_q;
        idx2_nxt   = idx2_q;
        lab1_nxt   = lab1_q;
        lab2_nxt   = lab2_q;
        player_nxt = player_q;
        score0_nxt = score0_q;
        score1_nxt = score1_q;
        sel_nxt    = '0;
        case (state)
            PICK1, PICK2: begin
                if (btn_sel && st[cur_q] == 4'hF) begin
                    sel_nxt = onehot(cur_q);
                    if (state == PICK1) begin
                        idx1_nxt  = cur_q;
                        state_nxt = WAIT1;
                    end else begin
                        idx2_nxt  = cur_q;
                        state_nxt = WAIT2;
                    end
                end else if (timeout) begin
                    player_nxt = ~player_q;
                    state_nxt  = NEXT;
                end else if (btn_move && !btn_sel && above_ok) begin
                    cur_nxt = above_idx;
                end
            end
            WAIT1: begin
                if (is_label(st[idx1_q])) begin
                    lab1_nxt = st[idx1_q];
                    if (above_ok) begin
                        cur_nxt   = above_idx;
                        state_nxt = PICK2;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            WAIT2: begin
                if (is_label(st[idx2_q])) begin
                    lab2_nxt  = st[idx2_q];
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (lab1_q == lab2_q) begin
                    state_nxt = PAR;
                end else begin
                    player_nxt = ~player_q;
                    state_nxt  = NEXT;
                end
            end
            PAR: begin
                if (player_q) score1_nxt = sat_inc(score1_q);
                else          score0_nxt = sat_inc(score0_q);
                state_nxt = NEXT;
            end
            NEXT: begin
                if (from_ok) begin
                    cur_nxt   = from_idx;
                    state_nxt = PICK1;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = PICK1;
        endcase
    end

`ifdef TURN_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMR_W-1:0] tmr_q;
    logic             tmr_clr;

    // Entering WAIT1/WAIT2 is exactly an accepted select.
    assign tmr_clr = (state_nxt != state) &&
                     (state_nxt == PICK1 || state_nxt == WAIT1 || state_nxt == WAIT2);
    assign timeout = (state == PICK1 || state == PICK2) && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  tmr_q <= '0;
        else if (tmr_clr)                          tmr_q <= '0;
        else if (tmr_q != TMR_W'(TIMEOUT_CYC - 1)) tmr_q <= tmr_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= PICK1;
            cur_q    <= '0;
            idx1_q   <= '0;
            idx2_q   <= '0;
            lab1_q   <= '0;
            lab2_q   <= '0;
            player_q <= 1'b0;
            score0_q <= '0;
            score1_q <= '0;
            sel_q    <= '0;
        end else begin
            state    <= state_nxt;
            cur_q    <= cur_nxt;
            idx1_q   <= idx1_nxt;
            idx2_q   <= idx2_nxt;
            lab1_q   <= lab1_nxt;
            lab2_q   <= lab2_nxt;
            player_q <= player_nxt;
            score0_q <= score0_nxt;
            score1_q <= score1_nxt;
            sel_q    <= sel_nxt;
        end
    end

    assign tile_cursor = (state == DONE) ? '0 : onehot(cur_q);
    assign tile_select = sel_q;
    assign tile_par    = (state == PAR) ? (onehot(idx1_q) | onehot(idx2_q)) : '0;
    assign player      = player_q;
    assign cursor_idx  = cur_q;
    assign score0      = score0_q;
    assign score1      = score1_q;
    assign game_over   = (state == DONE);

    always_comb begin
        winner = 2'b00;
        if (state == DONE) begin
            if (score0_q > score1_q)      winner = 2'b01;
            else if (score1_q > score0_q) winner = 2'b10;
            else                          winner = 2'b11;
        end
    end

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Bench for memory_turn_ctrl: a behavioural tile array answers the controller, and an
// action-level game model (hidden/revealed/matched per tile) predicts cursor, player, scores and result.
module tb_memory_turn_ctrl;
    localparam int N  = 16;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            btn_move = 1'b0;
    logic            btn_sel = 1'b0;
    logic [4*N-1:0]  tile_state;
    logic [N-1:0]    tile_cursor, tile_select, tile_par;
    logic            player;
    logic [IW-1:0]   cursor_idx;
    logic [4:0]      score0, score1;
    logic            game_over;
    logic [1:0]      winner;

    int vectors = 0;
    int miscompares = 0;

    memory_turn_ctrl #(.N_TILES(N), .IDX_W(IW), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst(rst), .btn_move(btn_move), .btn_sel(btn_sel),
        .tile_state(tile_state), .tile_cursor(tile_cursor), .tile_select(tile_select),
        .tile_par(tile_par), .player(player), .cursor_idx(cursor_idx),
        .score0(score0), .score1(score1), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // Tile array stand-in.
    logic [3:0] tst [N];
    logic [3:0] lab [N];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) tst[i] <= 4'h0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (tile_select[i])                        tst[i] <= lab[i];
                else if (tile_par[i])                      tst[i] <= player ? 4'hA : 4'h9;
                else if (tst[i] == 4'h0 && tile_cursor[i]) tst[i] <= 4'hF;
                else if (tst[i] == 4'hF && !tile_cursor[i]) tst[i] <= 4'h0;
            end
        end
    end
    always_comb begin
        tile_state = '0;
        for (int i = 0; i < N; i++) tile_state[4*i +: 4] = tst[i];
    end

    int         par_cnt = 0, sel_cnt = 0;
    logic [N-1:0] par_seen = '0, sel_seen = '0;
    always @(negedge clk) begin
        if (tile_par != '0)    begin par_cnt = par_cnt + 1; par_seen = tile_par; end
        if (tile_select != '0) begin sel_cnt = sel_cnt + 1; sel_seen = tile_select; end
    end

    // Game model: m_stat 0 hidden, 1 revealed, 2 matched.
    int m_cur, m_player, m_s0, m_s1, m_phase, m_i1, m_done;
    int m_stat [N];

    function automatic int next_hidden(input int from, input int k0);
        int jx;
        for (int k = k0; k < N; k++) begin
            jx = (from + k) % N;
            if (m_stat[jx] == 0) return jx;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_cur = 0; m_player = 0; m_s0 = 0; m_s1 = 0; m_phase = 1; m_i1 = 0; m_done = 0;
        for (int i = 0; i < N; i++) m_stat[i] = 0;
    endfunction

    function automatic void model_move();
        int n;
        if (m_done != 0) return;
        n = next_hidden(m_cur, 1);
        if (n >= 0) m_cur = n;
    endfunction

    function automatic void model_sel();
        int n;
        if (m_done != 0 || m_stat[m_cur] != 0) return;
        m_stat[m_cur] = 1;
        if (m_phase == 1) begin
            m_i1 = m_cur;
            n = next_hidden(m_cur, 1);
            if (n < 0) m_done = 1;
            else begin m_cur = n; m_phase = 2; end
        end else begin
            if (lab[m_i1] == lab[m_cur]) begin
                m_stat[m_i1] = 2; m_stat[m_cur] = 2;
                if (m_player == 0) m_s0 = (m_s0 < 31) ? m_s0 + 1 : 31;
                else               m_s1 = (m_s1 < 31) ? m_s1 + 1 : 31;
            end else begin
                m_player = 1 - m_player;
            end
            m_phase = 1;
            n = next_hidden(m_cur, 0);
            if (n < 0) m_done = 1;
            else m_cur = n;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int w;
        w = (m_done == 0) ? 0 : (m_s0 > m_s1) ? 1 : (m_s1 > m_s0) ? 2 : 3;
        chk({tag, " cursor_idx"}, 32'(cursor_idx), m_cur);
        chk({tag, " tile_cursor"}, 32'(tile_cursor), (m_done != 0) ? 0 : (32'd1 << m_cur));
        chk({tag, " player"}, 32'(player), m_player);
        chk({tag, " score0"}, 32'(score0), m_s0);
        chk({tag, " score1"}, 32'(score1), m_s1);
        chk({tag, " game_over"}, 32'(game_over), m_done);
        chk({tag, " winner"}, 32'(winner), w);
    endtask

    task automatic press(input logic mv, input logic sl, input logic tail_move);
        @(negedge clk); btn_move = mv; btn_sel = sl;
        @(negedge clk); btn_move = tail_move; btn_sel = 1'b0;
        @(negedge clk); btn_move = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // kind 0-3 move, 4-6 select, 7 both together (select wins), 8-9 select then a move dropped in WAIT.
    task automatic do_action(input int kind);
        if (kind <= 3)      begin press(1'b1, 1'b0, 1'b0); model_move(); end
        else if (kind <= 6) begin press(1'b0, 1'b1, 1'b0); model_sel(); end
        else if (kind == 7) begin press(1'b1, 1'b1, 1'b0); model_sel(); end
        else                begin press(1'b0, 1'b1, 1'b1); model_sel(); end
        check_all($sformatf("act%0d", kind));
    endtask

    task automatic play_random(input int max_steps);
        int steps;
        steps = 0;
        while (m_done == 0 && steps < max_steps) begin
            do_action(int'($urandom_range(0, 9)));
            steps++;
        end
        chk("game_finished", 32'(game_over), 1);
    endtask

    task automatic shuffle_labels();
        int r;
        logic [3:0] t;
        for (int i = 0; i < N; i++) lab[i] = 4'((i / 2) + 1);
        for (int i = N - 1; i > 0; i--) begin
            r = int'($urandom_range(0, i));
            t = lab[i]; lab[i] = lab[r]; lab[r] = t;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int p0, s0c;
        logic [3:0] fixed [N];
        fixed = '{4'd3, 4'd3, 4'd2, 4'd5, 4'd1, 4'd1, 4'd4, 4'd4,
                  4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd2, 4'd5};
        for (int i = 0; i < N; i++) lab[i] = fixed[i];
        model_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_all("reset");
        chk("reset tile_select", 32'(tile_select), 0);
        chk("reset tile_par", 32'(tile_par), 0);
        @(negedge clk);
        chk("tile0 highlight", 32'(tst[0]), 4'hF);

        // Cursor must update on the edge that samples the pulse.
        @(negedge clk); btn_move = 1'b1;
        @(negedge clk); btn_move = 1'b0;
        model_move();
        chk("move next cycle", 32'(cursor_idx), 1);
        repeat (3) @(negedge clk);
        do_action(0);
        do_action(0);
        chk("three moves", 32'(cursor_idx), 3);
        for (int i = 0; i < 12; i++) do_action(0);
        chk("cursor at 15", 32'(cursor_idx), 15);
        do_action(0);
        chk("wrap to 0", 32'(cursor_idx), 0);

        // Matching pair at tiles 0 and 1.
        s0c = sel_cnt;
        do_action(4);
        chk("select pulses", 32'(sel_cnt - s0c), 1);
        chk("select onehot", 32'(sel_seen), 32'h1);
        p0 = par_cnt;
        do_action(4);
        chk("par pulses", 32'(par_cnt - p0), 1);
        chk("par bits", 32'(par_seen), 32'h3);
        chk("tile0 matched", 32'(tst[0]), 4'h9);
        chk("tile1 matched", 32'(tst[1]), 4'h9);
        chk("score0 after match", 32'(score0), 1);
        chk("player kept", 32'(player), 0);

        // Mismatch at tiles 2 and 3.
        chk("cursor after match", 32'(cursor_idx), 2);
        p0 = par_cnt;
        do_action(4);
        do_action(4);
        chk("no par on mismatch", 32'(par_cnt - p0), 0);
        chk("player toggled", 32'(player), 1);
        chk("tile2 revealed", 32'(tst[2]), 4'h2);
        chk("tile3 revealed", 32'(tst[3]), 4'h5);
        for (int i = 0; i < 14; i++) do_action(0);

        repeat (1000) @(negedge clk);
        check_all("idle");

        play_random(400);
        for (int k = 0; k < 10; k += 3) do_action(k);

        for (int g = 0; g < 3; g++) begin
            @(negedge clk); rst = 1'b0;
            shuffle_labels();
            repeat (2) @(negedge clk);
            rst = 1'b1;
            model_reset();
            check_all("new game");
            if (g == 2) begin
                for (int i = 0; i < 10; i++) do_action(int'($urandom_range(0, 9)));
                @(negedge clk); rst = 1'b0;
                #1;
                model_reset();
                check_all("mid reset");
                for (int i = 0; i < N; i++) chk($sformatf("mid reset tile%0d", i), 32'(tst[i]), 0);
                do_reset();
            end
            play_random(400);
            do_action(4);
            do_action(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
